// File: rtl/clock_pkg.sv
// Shared constants for the time-keeping controller: state/field codes,
// field moduli and the raw time-field width.
package clock_pkg;

  localparam int FIELD_W = 6;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  // State codes double as the field_sel value seen by the display path.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous clear; carry is combinational so a
// chain of counters rolls over on a single edge.
module mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic               clk_src,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [FIELD_W-1:0] value,
  output logic               carry
);

  localparam logic [FIELD_W-1:0] LAST = FIELD_W'(MOD - 1);

  logic [FIELD_W-1:0] cnt_q, cnt_d;

  assign carry = inc && (cnt_q == LAST);
  assign value = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (carry) cnt_d = '0;
    else if (inc)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-of-day keeper with hour/minute/second setting modes, blink phase for
// the field being edited, and a one-cycle day rollover pulse.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HOUR_MOD = 24
) (
  input  logic             clk_src,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [WIDTH-1:0] sec_data,
  output logic [WIDTH-1:0] min_data,
  output logic [WIDTH-1:0] hour_data,
  output logic [1:0]       field_sel,
  output logic             blink_on,
  output logic             day_tick
);

  state_e state_q, state_d;
  logic   blink_q, blink_d;
  logic   day_tick_q, day_tick_d;

  logic sec_inc, sec_clr, min_inc, hour_inc;
  logic sec_carry, min_carry, hour_carry;
  logic [FIELD_W-1:0] sec_v, min_v, hour_v;

  always_comb begin
    state_d    = state_q;
    blink_d    = blink_q;
    sec_inc    = 1'b0;
    sec_clr    = 1'b0;
    min_inc    = 1'b0;
    hour_inc   = 1'b0;
    // A mode press wins over any same-cycle tick or increment.
    if (btn_mode) begin
      blink_d = 1'b1;
      unique case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end else begin
      unique case (state_q)
        RUN: begin
          blink_d  = 1'b1;
          sec_inc  = tick_1hz;
          min_inc  = sec_carry;
          hour_inc = min_carry;
        end
        SET_HOUR: begin
          blink_d  = blink_q ^ tick_1hz;
          hour_inc = btn_inc;
        end
        SET_MIN: begin
          blink_d = blink_q ^ tick_1hz;
          min_inc = btn_inc;
        end
        SET_SEC: begin
          blink_d = blink_q ^ tick_1hz;
          sec_clr = btn_inc;
        end
        default: state_d = RUN;
      endcase
    end
    // Hour wrap while editing is not a day boundary.
    day_tick_d = (state_q == RUN) && hour_carry;
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      blink_q    <= 1'b1;
      day_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blink_q    <= blink_d;
      day_tick_q <= day_tick_d;
    end
  end

  mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk_src(clk_src), .rst_n(rst_n), .inc(sec_inc), .clr(sec_clr),
    .value(sec_v), .carry(sec_carry)
  );

  mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk_src(clk_src), .rst_n(rst_n), .inc(min_inc), .clr(1'b0),
    .value(min_v), .carry(min_carry)
  );

  mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk_src(clk_src), .rst_n(rst_n), .inc(hour_inc), .clr(1'b0),
    .value(hour_v), .carry(hour_carry)
  );

  assign sec_data  = WIDTH'(sec_v);
  assign min_data  = WIDTH'(min_v);
  assign hour_data = WIDTH'(hour_v);
  assign field_sel = state_q;
  assign blink_on  = blink_q;
  assign day_tick  = day_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: vector table from reset plus
// hand-written multi-cycle sequences for rollover, setting and reset.
module tb_clock_time_ctrl;

  logic        clk_src = 1'b0;
  logic        rst_n   = 1'b0;
  logic        tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [31:0] sec_data, min_data, hour_data;
  logic [1:0]  field_sel;
  logic        blink_on, day_tick;

  int tests = 0, fails = 0;

  clock_time_ctrl #(.WIDTH(32), .HOUR_MOD(24)) dut (
    .clk_src(clk_src), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_data(sec_data), .min_data(min_data), .hour_data(hour_data),
    .field_sel(field_sel), .blink_on(blink_on), .day_tick(day_tick)
  );

  always #5 clk_src = ~clk_src;

  typedef struct {
    logic m, i, t;
    int   s, mi, h, f, b, d;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes; outputs are stable #1 after the edge.
  task automatic step(input logic m, input logic i, input logic t);
    @(negedge clk_src);
    btn_mode = m; btn_inc = i; tick_1hz = t;
    @(posedge clk_src);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic rep(input logic m, input logic i, input logic t, input int n);
    for (int k = 0; k < n; k++) step(m, i, t);
  endtask

  task automatic chk_time(input string name, input int h, input int mi, input int s);
    chk({name, ".hour"}, int'(hour_data), h);
    chk({name, ".min"},  int'(min_data),  mi);
    chk({name, ".sec"},  int'(sec_data),  s);
  endtask

  initial begin
    //          m  i  t   s mi  h  f  b  d
    vecs[0]  = '{0, 0, 1,  1, 0, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 1,  2, 0, 0, 0, 1, 0};
    vecs[2]  = '{1, 0, 0,  2, 0, 0, 1, 1, 0};
    vecs[3]  = '{0, 0, 1,  2, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0,  2, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 1,  2, 0, 2, 1, 1, 0};
    vecs[6]  = '{1, 1, 0,  2, 0, 2, 2, 1, 0};
    vecs[7]  = '{0, 1, 0,  2, 1, 2, 2, 1, 0};
    vecs[8]  = '{0, 0, 1,  2, 1, 2, 2, 0, 0};
    vecs[9]  = '{1, 0, 0,  2, 1, 2, 3, 1, 0};
    vecs[10] = '{0, 1, 0,  0, 1, 2, 3, 1, 0};
    vecs[11] = '{0, 0, 1,  0, 1, 2, 3, 0, 0};
    vecs[12] = '{1, 0, 1,  0, 1, 2, 0, 1, 0};
    vecs[13] = '{0, 0, 1,  1, 1, 2, 0, 1, 0};
    vecs[14] = '{1, 0, 1,  1, 1, 2, 1, 1, 0};
    vecs[15] = '{1, 0, 0,  1, 1, 2, 2, 1, 0};
    vecs[16] = '{1, 0, 0,  1, 1, 2, 3, 1, 0};
    vecs[17] = '{1, 0, 0,  1, 1, 2, 0, 1, 0};
    vecs[18] = '{0, 0, 0,  1, 1, 2, 0, 1, 0};

    // Reset state while held
    #12;
    chk_time("rst0", 0, 0, 0);
    chk("rst0.field", int'(field_sel), 0);
    chk("rst0.blink", int'(blink_on), 1);
    chk("rst0.day",   int'(day_tick), 0);
    @(negedge clk_src); rst_n = 1'b1;

    foreach (vecs[n]) begin
      step(vecs[n].m, vecs[n].i, vecs[n].t);
      chk($sformatf("v%0d.sec", n),   int'(sec_data),  vecs[n].s);
      chk($sformatf("v%0d.min", n),   int'(min_data),  vecs[n].mi);
      chk($sformatf("v%0d.hour", n),  int'(hour_data), vecs[n].h);
      chk($sformatf("v%0d.field", n), int'(field_sel), vecs[n].f);
      chk($sformatf("v%0d.blink", n), int'(blink_on),  vecs[n].b);
      chk($sformatf("v%0d.day", n),   int'(day_tick),  vecs[n].d);
    end

    // Set 03:02:00 from reset, then ten ticks in SET_MIN toggle blink only
    @(negedge clk_src); rst_n = 1'b0;
    @(negedge clk_src); rst_n = 1'b1;
    step(1, 0, 0); rep(0, 1, 0, 3);
    step(1, 0, 0); rep(0, 1, 0, 2);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 1);
      chk($sformatf("blink_tog%0d", k), int'(blink_on), (k % 2 == 0) ? 1 : 0);
    end
    chk("setseq.field", int'(field_sel), 2);
    chk_time("setseq", 3, 2, 0);

    // Hour wrap while editing: no carry, no day_tick
    rep(1, 0, 0, 3);
    rep(0, 1, 0, 20);
    chk("sethr23.hour", int'(hour_data), 23);
    step(0, 1, 0);
    chk_time("sethr_wrap", 0, 2, 0);
    chk("sethr_wrap.day", int'(day_tick), 0);

    // Build 23:59:59 and roll the day over
    rep(0, 1, 0, 23);
    step(1, 0, 0); rep(0, 1, 0, 57);
    step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0);
    rep(0, 0, 1, 59);
    chk_time("pre_roll", 23, 59, 59);
    chk("pre_roll.field", int'(field_sel), 0);
    step(0, 0, 1);
    chk_time("roll", 0, 0, 0);
    chk("roll.day", int'(day_tick), 1);
    step(0, 0, 0);
    chk("roll.day_after", int'(day_tick), 0);

    // SET_SEC clears 47 to 0, then RUN resumes counting
    rep(0, 0, 1, 47);
    rep(1, 0, 0, 3);
    chk("setsec.field", int'(field_sel), 3);
    chk("setsec.sec47", int'(sec_data), 47);
    step(0, 1, 0);
    chk("setsec.clr", int'(sec_data), 0);
    step(1, 0, 0);
    chk("setsec.run_field", int'(field_sel), 0);
    chk("setsec.run_blink", int'(blink_on), 1);
    step(0, 0, 1);
    chk_time("resume", 0, 0, 1);

    // Mode and inc together in RUN: mode wins, hour untouched
    step(1, 1, 0);
    chk("modeinc.field", int'(field_sel), 1);
    chk("modeinc.hour", int'(hour_data), 0);

    // Reach 12:34:56 and apply reset asynchronously mid-cycle
    rep(0, 1, 0, 12);
    step(1, 0, 0); rep(0, 1, 0, 34);
    step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0);
    rep(0, 0, 1, 56);
    chk_time("pre_rst", 12, 34, 56);
    @(negedge clk_src); rst_n = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst.field", int'(field_sel), 0);
    chk("async_rst.blink", int'(blink_on), 1);
    chk("async_rst.day",   int'(day_tick), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
